// File: rtl/game_controller.sv
// Central FSM of the digit-matching game: sequences timer reload, target requests,
// answer checking, level progression and the game-over / logout hand-off.
module game_controller #(
  parameter int unsigned HITS_PER_LEVEL = 4,
  parameter int unsigned MAX_LEVEL      = 3,
  parameter logic [3:0]  BLANK          = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       logged_in,
  input  logic       btn,
  input  logic [3:0] userInput,
  input  logic [3:0] rand_digit,
  input  logic       rand_valid,
  input  logic       timeout,
  input  logic       pulse_2s,
  output logic       seq_start,
  output logic       timerReconfig,
  output logic       timerEnable,
  output logic [1:0] gameLevel,
  output logic       enable_2s,
  output logic [3:0] player_digit,
  output logic [3:0] rand_display,
  output logic [6:0] score,
  output logic       gc_logout
);
  localparam int unsigned   HW        = $clog2(HITS_PER_LEVEL + 1);
  localparam logic [HW-1:0] HITS_TGT  = HW'(HITS_PER_LEVEL);
  localparam logic [1:0]    LVL_MAX   = 2'(MAX_LEVEL);
  localparam logic [6:0]    SCORE_MAX = 7'd99;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RECONFIG = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_PLAY     = 3'd4;
  localparam logic [2:0] S_GAMEOVER = 3'd5;
  localparam logic [2:0] S_LOGOUT   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [3:0]    target_q, target_d;
  logic [3:0]    last_sub_q, last_sub_d;
  logic [HW-1:0] hits_q, hits_d, hits_inc;
  logic [6:0]    score_q, score_d;
  logic [1:0]    level_q, level_d;
  logic          seq_start_q, seq_start_d;
  logic          reconfig_q, reconfig_d;
  logic          ten_q, ten_d;
  logic          en2_q, en2_d;
  logic [3:0]    pd_q, pd_d;
  logic [3:0]    rd_q, rd_d;
  logic          logout_q, logout_d;

  assign hits_inc = hits_q + HW'(1);

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    last_sub_d = last_sub_q;
    hits_d     = hits_q;
    score_d    = score_q;
    level_d    = level_q;
    // Losing the login aborts the session silently, whatever else is happening.
    if (state_q != S_IDLE && !logged_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (logged_in && btn) begin
            score_d    = '0;
            level_d    = '0;
            hits_d     = '0;
            last_sub_d = BLANK;
            state_d    = S_RECONFIG;
          end
        end
        S_RECONFIG: state_d = S_REQ;
        S_REQ:      state_d = S_WAIT;
        S_WAIT: begin
          if (rand_valid) begin
            target_d = rand_digit;
            state_d  = S_PLAY;
          end
        end
        S_PLAY: begin
          if (timeout) begin
            state_d = S_GAMEOVER;
          end else if (btn) begin
            last_sub_d = userInput;
            state_d    = S_REQ;
            if (userInput == target_q) begin
              score_d = (score_q == SCORE_MAX) ? score_q : score_q + 7'd1;
              if (hits_inc == HITS_TGT) begin
                hits_d = '0;
                if (level_q < LVL_MAX) begin
                  level_d = level_q + 2'd1;
                  state_d = S_RECONFIG;
                end
              end else begin
                hits_d = hits_inc;
              end
            end
          end
        end
        S_GAMEOVER: if (pulse_2s) state_d = S_LOGOUT;
        S_LOGOUT:   state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    seq_start_d = (state_d == S_REQ);
    reconfig_d  = (state_d == S_RECONFIG);
    en2_d       = (state_d == S_GAMEOVER);
    logout_d    = (state_d == S_LOGOUT);
    ten_d       = 1'b0;
    pd_d        = BLANK;
    rd_d        = BLANK;
    case (state_d)
      S_RECONFIG, S_REQ, S_WAIT: begin
        ten_d = ten_q;
        pd_d  = pd_q;
        rd_d  = rd_q;
      end
      S_PLAY: begin
        ten_d = 1'b1;
        pd_d  = userInput;
        rd_d  = target_d;
      end
      S_GAMEOVER: begin
        pd_d = last_sub_d;
        rd_d = rd_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      last_sub_q  <= BLANK;
      hits_q      <= '0;
      score_q     <= '0;
      level_q     <= '0;
      seq_start_q <= 1'b0;
      reconfig_q  <= 1'b0;
      ten_q       <= 1'b0;
      en2_q       <= 1'b0;
      pd_q        <= BLANK;
      rd_q        <= BLANK;
      logout_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      last_sub_q  <= last_sub_d;
      hits_q      <= hits_d;
      score_q     <= score_d;
      level_q     <= level_d;
      seq_start_q <= seq_start_d;
      reconfig_q  <= reconfig_d;
      ten_q       <= ten_d;
      en2_q       <= en2_d;
      pd_q        <= pd_d;
      rd_q        <= rd_d;
      logout_q    <= logout_d;
    end
  end

  assign seq_start     = seq_start_q;
  assign timerReconfig = reconfig_q;
  assign timerEnable   = ten_q;
  assign gameLevel     = level_q;
  assign enable_2s     = en2_q;
  assign player_digit  = pd_q;
  assign rand_display  = rd_q;
  assign score         = score_q;
  assign gc_logout     = logout_q;
endmodule

// File: doc/game_controller.md
# game_controller

Central FSM of the digit-matching game. It sits between the multi-user authenticator (login status), the digit sequencer and RAM (random target digits), and the timers. It drives the two-digit countdown timer's reconfigure, enable and level inputs and the 2 s timer's enable, and consumes the countdown timeout. It also feeds the player and random-number 7-segment decoders, and ends a session with a logout pulse.

## Interface
- HITS_PER_LEVEL, 4, correct answers needed to advance one level
- MAX_LEVEL, 3, highest gameLevel value (saturates)
- BLANK, 4'hF, display code meaning "segment off"
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- logged_in  in  1  level; a user is authenticated
- btn  in  1  one-cycle shaped start/submit pulse
- userInput  in  4  player's switch digit
- rand_digit  in  4  target digit from sequencer
- rand_valid  in  1  one-cycle strobe; rand_digit valid
- timeout  in  1  countdown reached 00
- pulse_2s  in  1  one-cycle 2 s tick from the two-second timer
- seq_start  out  1  one-cycle request to the sequencer
- timerReconfig  out  1  one-cycle reload of the countdown
- timerEnable  out  1  countdown runs while high
- gameLevel  out  2  current level, 0..MAX_LEVEL
- enable_2s  out  1  enables the two-second timer
- player_digit  out  4  to the player display decoder
- rand_display  out  4  to the random-number display decoder
- score  out  7  correct answers this game, saturates at 99
- gc_logout  out  1  one-cycle session end pulse

## Operation
- All outputs are registered. Reset values: seq_start=0, timerReconfig=0, timerEnable=0, gameLevel=0, enable_2s=0, player_digit=BLANK, rand_display=BLANK, score=0, gc_logout=0. State is IDLE.
- IDLE:
  - Displays show BLANK.
  - On logged_in && btn: clear score, gameLevel and the hit counter, then go to RECONFIG.
- RECONFIG: timerReconfig=1 for exactly one cycle, with the current gameLevel stable on the same cycle. Go to REQ.
- REQ: seq_start=1 for exactly one cycle. Go to WAIT_RAND.
- WAIT_RAND:
  - timerEnable holds its previous value. It is 0 on the first round and stays 1 after a REQ entered from PLAY.
  - On rand_valid: latch rand_digit, then go to PLAY.
- PLAY:
  - timerEnable=1, rand_display=latched digit, player_digit=userInput registered each cycle.
  - On btn, compare userInput with the latched digit:
    - Match: score+1, saturating at 99, and hit counter+1.
    - If the hit counter reaches HITS_PER_LEVEL: clear it. If gameLevel<MAX_LEVEL, increment gameLevel and go to RECONFIG (timer reloads for the new level). Otherwise go to REQ.
    - Match below threshold: go to REQ.
    - Mismatch: score unchanged, go to REQ (new target, timer keeps running).
  - On timeout: go to GAMEOVER.
- GAMEOVER:
  - timerEnable=0, enable_2s=1.
  - rand_display keeps the last target; player_digit keeps the last submitted value.
  - On pulse_2s: go to LOGOUT.
- LOGOUT:
  - gc_logout=1 for one cycle, enable_2s=0, displays BLANK.
  - Go to IDLE. score holds its value until the next game start.
- Priority rules:
  - logged_in low in any state other than IDLE: next cycle the state is IDLE, timerEnable=0, enable_2s=0, displays are BLANK, and no gc_logout is issued.
  - In PLAY, timeout and btn on the same cycle: timeout wins and the answer is discarded.
  - btn in any state other than IDLE and PLAY is ignored.
  - rand_valid outside WAIT_RAND is ignored.

## Timing
- btn to seq_start (IDLE path): btn at cycle n gives RECONFIG at n+1, timerReconfig high in n+1, and seq_start high in n+2.
- rand_valid at cycle m: rand_display is updated and timerEnable=1 from m+1.
- Submit in PLAY at cycle k: score is updated at k+1. seq_start is high at k+1 (REQ path) or at k+2 (RECONFIG path).
- Timeout at cycle t: timerEnable=0 and enable_2s=1 from t+1. gc_logout is high the cycle after pulse_2s is sampled.
- An asynchronous reset mid-game returns all outputs to their reset values immediately.

## Test plan
- Reset, then logged_in=1 and btn: timerReconfig pulses with gameLevel=0, and seq_start pulses exactly one cycle later.
- rand_valid with rand_digit=7, then userInput=7 and btn: score=1, rand_display=7 before the submit, and a new seq_start.
- userInput=3 with target 7, then btn: score stays 0, timerEnable stays 1, and a new seq_start.
- Four consecutive hits: gameLevel=1, timerReconfig pulses, and the hit counter restarts. Sixteen hits: gameLevel saturates at 3 with no further RECONFIG.
- timeout and btn on the same cycle: state goes to GAMEOVER, score is unchanged, and enable_2s=1. Then pulse_2s: gc_logout is high one cycle and the state returns to IDLE.
- logged_in dropped during PLAY: state is IDLE the next cycle, both displays are BLANK, timerEnable=0, and gc_logout never asserts.
